// File: rtl/bitstream_101_scan_ctrl.sv
// Word-to-serial sequencer for a 101 detector: clears the detector, shifts a word MSB-first,
// drains the detector pipeline and reports the saturating hit count for the word.
module bitstream_101_scan_ctrl #(
    parameter int W     = 8,
    parameter int CW    = 4,
    parameter int DRAIN = 2
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic [W-1:0]  iDATA,
    input  logic          iVALID,
    output logic          oREADY,
    output logic          oDET_RST,
    output logic          oDET_IN,
    input  logic          iDET_OUT,
    output logic [CW-1:0] oCOUNT,
    output logic          oDONE,
    output logic          oBUSY,
    output logic [2:0]    oSTATE
);

    // Handshake: a word transfers on a rising edge where iVALID & oREADY are both high;
    // oREADY is high only in IDLE, so iVALID held in any other state is not consumed.

    localparam int BW  = (W > 1) ? $clog2(W) : 1;
    localparam int DCW = $clog2(DRAIN + 1);
    localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t         state;
    state_t         nextState;
    logic [W-1:0]   shiftReg;
    logic [BW-1:0]  bitCtr;
    logic [DCW-1:0] drainCtr;
    logic [CW-1:0]  count;
    logic           hit;

    // Hits arriving once the counter is full are dropped instead of wrapping.
    assign hit = iDET_OUT && (count != COUNT_MAX);

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state    <= ST_IDLE;
            shiftReg <= '0;
            bitCtr   <= '0;
            drainCtr <= '0;
            count    <= '0;
        end else begin
            state <= nextState;
            case (state)
                ST_IDLE: begin
                    if (iVALID) begin
                        shiftReg <= iDATA;
                        count    <= '0;
                        bitCtr   <= BW'(W - 1);
                    end
                end
                ST_SHIFT: begin
                    shiftReg <= {shiftReg[W-2:0], 1'b0};
                    bitCtr   <= bitCtr - 1'b1;
                    if (bitCtr == '0) begin
                        drainCtr <= DCW'(DRAIN - 1);
                    end
                    if (hit) begin
                        count <= count + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    drainCtr <= drainCtr - 1'b1;
                    if (hit) begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:  if (iVALID) nextState = ST_CLR;
            ST_CLR:   nextState = ST_SHIFT;
            ST_SHIFT: if (bitCtr == '0) nextState = ST_DRAIN;
            ST_DRAIN: if (drainCtr == '0) nextState = ST_DONE;
            ST_DONE:  nextState = ST_IDLE;
            default:  nextState = ST_IDLE;
        endcase
    end

    // Detector reset follows iRST combinationally so both blocks reset on the same edge.
    assign oDET_RST = iRST & (state != ST_CLR);
    assign oDET_IN  = (state == ST_SHIFT) & shiftReg[W-1];
    assign oREADY   = (state == ST_IDLE);
    assign oBUSY    = (state != ST_IDLE);
    assign oDONE    = (state == ST_DONE) & iRST;
    assign oCOUNT   = count;
    assign oSTATE   = state;

endmodule

// File: tb/tb_bitstream_101_scan_ctrl.sv
// Bench for bitstream_101_scan_ctrl: two controllers (CW=4 and CW=1) each drive a behavioural
// non-overlapping 101 detector with 2-cycle latency; hit counts are checked against a string-scan model.
module tb_bitstream_101_scan_ctrl;

  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       valid;

  logic       ready0, detRst0, detIn0, detOut0, done0, busy0;
  logic [3:0] count0;
  logic [2:0] state0;
  logic       ready1, detRst1, detIn1, detOut1, done1, busy1;
  logic [0:0] count1;
  logic [2:0] state1;

  int checks = 0;
  int errors = 0;

  bitstream_101_scan_ctrl #(.W(8), .CW(4), .DRAIN(2)) dut0 (
    .iCLK(clk), .iRST(rst), .iDATA(data), .iVALID(valid), .oREADY(ready0),
    .oDET_RST(detRst0), .oDET_IN(detIn0), .iDET_OUT(detOut0), .oCOUNT(count0),
    .oDONE(done0), .oBUSY(busy0), .oSTATE(state0)
  );

  bitstream_101_scan_ctrl #(.W(8), .CW(1), .DRAIN(2)) dut1 (
    .iCLK(clk), .iRST(rst), .iDATA(data), .iVALID(valid), .oREADY(ready1),
    .oDET_RST(detRst1), .oDET_IN(detIn1), .iDET_OUT(detOut1), .oCOUNT(count1),
    .oDONE(done1), .oBUSY(busy1), .oSTATE(state1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- detector models (non-overlapping 101, in->out latency 2) ----------------
  logic [1:0] hist [2];
  logic [1:0] avail[2];
  logic       matchR[2];
  logic       outR[2];
  logic       dRst[2];
  logic       dIn[2];

  assign dRst[0] = detRst0;
  assign dRst[1] = detRst1;
  assign dIn[0]  = detIn0;
  assign dIn[1]  = detIn1;
  assign detOut0 = outR[0];
  assign detOut1 = outR[1];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!dRst[k]) begin
        hist[k]   <= '0;
        avail[k]  <= '0;
        matchR[k] <= 1'b0;
        outR[k]   <= 1'b0;
      end else begin
        matchR[k] <= (avail[k] >= 2'd2) && (hist[k] == 2'b10) && dIn[k];
        hist[k]   <= {hist[k][0], dIn[k]};
        if ((avail[k] >= 2'd2) && (hist[k] == 2'b10) && dIn[k])
          avail[k] <= 2'd0;
        else if (avail[k] < 2'd2)
          avail[k] <= avail[k] + 2'd1;
        outR[k] <= matchR[k];
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int refHits(input logic [7:0] w, input int maxCount);
    int i = 0;
    int n = 0;
    while (i <= W - 3) begin
      if (w[W-1-i] && !w[W-2-i] && w[W-3-i]) begin
        n++;
        i += 3;
      end else begin
        i++;
      end
    end
    return (n > maxCount) ? maxCount : n;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word, follows it through CLR/SHIFT/DRAIN/DONE and checks the result.
  task automatic scanWord(input logic [7:0] word);
    logic [7:0] serial;
    int         doneAt;
    bit         readyLeak;
    bit         drainLeak;
    logic [3:0] cnt0;
    logic [0:0] cnt1;
    int         exp0;
    int         exp1;
    exp0 = refHits(word, 15);
    exp1 = refHits(word, 1);
    serial = '0;
    doneAt = -1;
    readyLeak = 0;
    drainLeak = 0;
    cnt0 = '0;
    cnt1 = '0;
    data  = word;
    valid = 1'b1;
    tick();
    valid = 1'b1;
    data  = 8'($urandom);
    for (int c = 0; c <= 11; c++) begin
      if (c == 0) begin
        check("det_rst_in_clr", {31'd0, detRst0}, 32'd0);
        check("busy_in_clr", {31'd0, busy0}, 32'd1);
      end
      if (c >= 1 && c <= 8) serial[8-c] = detIn0;
      if ((c == 0 || c == 9 || c == 10) && detIn0) drainLeak = 1;
      if (done0 && doneAt < 0) doneAt = c;
      if (ready0) readyLeak = 1;
      if (c == 11) begin
        cnt0 = count0;
        cnt1 = count1;
      end
      if (c == 1) valid = 1'($urandom_range(0, 1));
      if (c < 11) tick();
    end
    check("serial_bits", {24'd0, serial}, {24'd0, word});
    check("done_latency", doneAt, 11);
    check("ready_low_busy", {31'd0, readyLeak}, 32'd0);
    check("det_in_idle_zero", {31'd0, drainLeak}, 32'd0);
    check("count_cw4", {28'd0, cnt0}, exp0);
    check("count_cw1", {31'd0, cnt1}, exp1);
    valid = 1'b0;
    tick();
    check("ready_after_done", {31'd0, ready0}, 32'd1);
    check("count_stable", {28'd0, count0}, exp0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [7:0] wordB;
    rst = 1'b0;
    valid = 1'b0;
    data = '0;
    repeat (3) tick();
    check("rst_det_rst", {31'd0, detRst0}, 32'd0);
    check("rst_ready", {31'd0, ready0}, 32'd1);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_count", {28'd0, count0}, 32'd0);
    rst = 1'b1;
    #1;
    check("det_rst_released", {31'd0, detRst0}, 32'd1);
    tick();

    // directed words
    scanWord(8'b10101101);
    scanWord(8'b10101010);
    scanWord(8'h00);
    scanWord(8'hFF);
    scanWord(8'b00000101);

    // back-to-back with iVALID held high
    data  = 8'b10101101;
    valid = 1'b1;
    tick();
    wordB = 8'b10101010;
    data  = wordB;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done0) check("b2b_first_count", {28'd0, count0}, refHits(8'b10101101, 15));
      if (ready0) begin
        k = c;
        break;
      end
    end
    check("b2b_accept_gap", k + 1, 13);
    scanWord(wordB);

    // reset during the 4th SHIFT cycle
    data  = 8'b10101101;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    check("midrst_det_rst", {31'd0, detRst0}, 32'd0);
    tick();
    rst = 1'b1;
    check("midrst_ready", {31'd0, ready0}, 32'd1);
    check("midrst_count", {28'd0, count0}, 32'd0);
    check("midrst_busy", {31'd0, busy0}, 32'd0);
    k = 0;
    for (int c = 0; c < 16; c++) begin
      if (done0 || done1) k++;
      tick();
    end
    check("midrst_no_done", k, 0);

    // randomized words
    for (int n = 0; n < 40; n++) begin
      scanWord(8'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
